demux32b_reg: RTL and testbench

- Registered 1-to-2 demultiplexer: the write-side counterpart of the datapath 2:1 selector.
- Routes one DATA_WIDTH word from a single producer to one of two consumers: channel 1 (instruction path) or channel 2 (register bank path).
- Valid/ready handshake on the input side and on both output sides.
- Each output channel has its own one-entry holding register, so one stalled consumer never corrupts the other.

---
 rtl/demux32b_reg_pkg.sv | 20 ++
 rtl/demux32b_reg_canal_saida.sv | 69 ++++++
 rtl/demux32b_reg.sv | 70 +++++++
 tb/tb_demux32b_reg.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux32b_reg_pkg.sv
// rtl/demux32b_reg_pkg.sv - shared constants and types for the registered 1-to-2 demultiplexer
package demux32b_reg_pkg;

   // Default word width on every data port
   localparam int DATA_WIDTH_PAD = 32;

   // Holding-register occupancy per output channel
   typedef enum logic {
      VAZIO = 1'b0,
      CHEIO = 1'b1
   } estado_t;

   // selecao polarity, same as the 2:1 selector on the read side
   localparam logic SEL_CANAL1 = 1'b1;
   localparam logic SEL_CANAL2 = 1'b0;

   // Width of the optional drain counters
   localparam int CONTADOR_WIDTH = 32;

endpackage

// File: rtl/demux32b_reg_canal_saida.sv
// rtl/demux32b_reg_canal_saida.sv - one-entry output holding register with VAZIO/CHEIO FSM (drain counter under DEMUX_CONTADOR_EN)
module demux32b_reg_canal_saida
   import demux32b_reg_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_PAD
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  carga_i,
   input  logic [DATA_WIDTH-1:0] dado_i,
   input  logic                  pronta_i,
   output logic                  valida_o,
   output logic                  pode_aceitar_o,
   output logic [DATA_WIDTH-1:0] dado_o
`ifdef DEMUX_CONTADOR_EN
   ,
   output logic [CONTADOR_WIDTH-1:0] contador_o
`endif
);

   estado_t               estado_q, estado_d;
   logic [DATA_WIDTH-1:0] dado_q, dado_d;
   logic                  drena;

   assign valida_o       = (estado_q == CHEIO);
   assign drena          = valida_o && pronta_i;
   // A full register still accepts when its consumer takes the old word this edge
   assign pode_aceitar_o = (estado_q == VAZIO) || pronta_i;
   assign dado_o         = dado_q;

   // Next state: a load wins over a drain so back-to-back words flow at one per cycle
   always_comb begin
      estado_d = estado_q;
      dado_d   = dado_q;
      if (carga_i) begin
         estado_d = CHEIO;
         dado_d   = dado_i;
      end else if (drena) begin
         estado_d = VAZIO;
      end
   end

   // Holding register and occupancy; data is kept after a drain, only reset clears it
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q <= VAZIO;
         dado_q   <= '0;
      end else begin
         estado_q <= estado_d;
         dado_q   <= dado_d;
      end
   end

`ifdef DEMUX_CONTADOR_EN
   logic [CONTADOR_WIDTH-1:0] contador_q;

   assign contador_o = contador_q;

   // Drain counter, wraps naturally at the top of its range
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         contador_q <= '0;
      end else if (drena) begin
         contador_q <= contador_q + 1'b1;
      end
   end
`endif

endmodule

// File: rtl/demux32b_reg.sv
// rtl/demux32b_reg.sv - registered 1-to-2 demultiplexer with valid/ready handshakes (optional DEMUX_CONTADOR_EN drain counters)
module demux32b_reg
   import demux32b_reg_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_PAD
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] entrada,
   input  logic                  entrada_valida,
   input  logic                  selecao,
   output logic                  entrada_pronta,
   output logic [DATA_WIDTH-1:0] saida1,
   output logic                  saida1_valida,
   input  logic                  saida1_pronta,
   output logic [DATA_WIDTH-1:0] saida2,
   output logic                  saida2_valida,
   input  logic                  saida2_pronta
`ifdef DEMUX_CONTADOR_EN
   ,
   output logic [CONTADOR_WIDTH-1:0] contador1,
   output logic [CONTADOR_WIDTH-1:0] contador2
`endif
);

   logic aceita1, aceita2;
   logic transfere;
   logic carga1, carga2;

   // Readiness comes only from the selected channel, so a full idle channel never blocks the other
   assign entrada_pronta = (selecao == SEL_CANAL1) ? aceita1 : aceita2;
   assign transfere      = entrada_valida && entrada_pronta;
   assign carga1         = transfere && (selecao == SEL_CANAL1);
   assign carga2         = transfere && (selecao == SEL_CANAL2);

   demux32b_reg_canal_saida #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_canal1 (
      .clock          (clock),
      .reset          (reset),
      .carga_i        (carga1),
      .dado_i         (entrada),
      .pronta_i       (saida1_pronta),
      .valida_o       (saida1_valida),
      .pode_aceitar_o (aceita1),
      .dado_o         (saida1)
`ifdef DEMUX_CONTADOR_EN
      ,
      .contador_o     (contador1)
`endif
   );

   demux32b_reg_canal_saida #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_canal2 (
      .clock          (clock),
      .reset          (reset),
      .carga_i        (carga2),
      .dado_i         (entrada),
      .pronta_i       (saida2_pronta),
      .valida_o       (saida2_valida),
      .pode_aceitar_o (aceita2),
      .dado_o         (saida2)
`ifdef DEMUX_CONTADOR_EN
      ,
      .contador_o     (contador2)
`endif
   );

endmodule

// File: tb/tb_demux32b_reg.sv
// tb/tb_demux32b_reg.sv - self-checking bench for demux32b_reg (DEMUX_CONTADOR_EN adds counter checks)
module tb_demux32b_reg;

   logic        clock;
   logic        reset;
   logic [31:0] entrada;
   logic        entrada_valida;
   logic        selecao;
   logic        entrada_pronta;
   logic [31:0] saida1;
   logic        saida1_valida;
   logic        saida1_pronta;
   logic [31:0] saida2;
   logic        saida2_valida;
   logic        saida2_pronta;
`ifdef DEMUX_CONTADOR_EN
   logic [31:0] contador1;
   logic [31:0] contador2;
`endif

   int checks = 0;
   int errors = 0;

   demux32b_reg #(.DATA_WIDTH(32)) dut (
      .clock          (clock),
      .reset          (reset),
      .entrada        (entrada),
      .entrada_valida (entrada_valida),
      .selecao        (selecao),
      .entrada_pronta (entrada_pronta),
      .saida1         (saida1),
      .saida1_valida  (saida1_valida),
      .saida1_pronta  (saida1_pronta),
      .saida2         (saida2),
      .saida2_valida  (saida2_valida),
      .saida2_pronta  (saida2_pronta)
`ifdef DEMUX_CONTADOR_EN
      ,
      .contador1      (contador1),
      .contador2      (contador2)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] din;
      logic        val;
      logic        sel;
      logic        p1;
      logic        p2;
      logic        rdy;
      logic        v1;
      logic        v2;
      logic [31:0] s1;
      logic [31:0] s2;
   } vec_t;

   vec_t tbl[15];

   // Reference model: each channel is a queue of at most one word, plus last word shown
   logic [31:0] q1[$];
   logic [31:0] q2[$];
   logic [31:0] last1, last2;
   int          cnt1, cnt2;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] din, input logic val, input logic sel,
                               input logic p1, input logic p2, input logic rdy,
                               input logic v1, input logic v2,
                               input logic [31:0] s1, input logic [31:0] s2);
      vec_t v;
      v.din = din; v.val = val; v.sel = sel; v.p1 = p1; v.p2 = p2;
      v.rdy = rdy; v.v1 = v1; v.v2 = v2; v.s1 = s1; v.s2 = s2;
      return v;
   endfunction

   task automatic drive(input logic [31:0] d, input logic v, input logic s,
                        input logic p1, input logic p2);
      entrada        = d;
      entrada_valida = v;
      selecao        = s;
      saida1_pronta  = p1;
      saida2_pronta  = p2;
   endtask

   task automatic model_reset();
      q1.delete();
      q2.delete();
      last1 = '0;
      last2 = '0;
      cnt1  = 0;
      cnt2  = 0;
   endtask

   // One randomized cycle checked against the queue model
   task automatic rand_step();
      logic [31:0] d;
      logic v, s, p1, p2, exp_rdy, acc;
      @(negedge clock);
      d  = $urandom;
      v  = ($urandom_range(0, 3) != 0);
      s  = $urandom_range(0, 1) != 0;
      p1 = $urandom_range(0, 2) != 0;
      p2 = $urandom_range(0, 2) != 0;
      drive(d, v, s, p1, p2);
      #1;
      exp_rdy = s ? (q1.size() == 0 || p1) : (q2.size() == 0 || p2);
      check("rnd_entrada_pronta", {31'd0, entrada_pronta}, {31'd0, exp_rdy});
      acc = v && exp_rdy;
      if (q1.size() != 0 && p1) begin
         check("rnd_drain1_word", saida1, q1[0]);
         void'(q1.pop_front());
         cnt1++;
      end
      if (q2.size() != 0 && p2) begin
         check("rnd_drain2_word", saida2, q2[0]);
         void'(q2.pop_front());
         cnt2++;
      end
      if (acc && s) begin q1.push_back(d); last1 = d; end
      if (acc && !s) begin q2.push_back(d); last2 = d; end
      @(posedge clock);
      #1;
      check("rnd_saida1_valida", {31'd0, saida1_valida}, (q1.size() != 0) ? 32'd1 : 32'd0);
      check("rnd_saida2_valida", {31'd0, saida2_valida}, (q2.size() != 0) ? 32'd1 : 32'd0);
      check("rnd_saida1", saida1, last1);
      check("rnd_saida2", saida2, last2);
`ifdef DEMUX_CONTADOR_EN
      check("rnd_contador1", contador1, cnt1);
      check("rnd_contador2", contador2, cnt2);
`endif
   endtask

   initial begin
      // Directed vectors starting from the reset state
      tbl[0]  = mk(32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0);
      tbl[1]  = mk(32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0);
      tbl[2]  = mk(32'h12345678, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 32'h12345678);
      tbl[3]  = mk(32'hA5A5A5A5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 32'h12345678);
      tbl[4]  = mk(32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA5A5A5A5, 32'h12345678);
      tbl[5]  = mk(32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA5A5A5A5, 32'h12345678);
      tbl[6]  = mk(32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h12345678);
      tbl[7]  = mk(32'h1,        1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1, 32'h12345678);
      tbl[8]  = mk(32'h2,        1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h2, 32'h12345678);
      tbl[9]  = mk(32'h3,        1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3, 32'h12345678);
      tbl[10] = mk(32'h4,        1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h4, 32'h12345678);
      tbl[11] = mk(32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h12345678);
      tbl[12] = mk(32'h10,       1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h12345678);
      tbl[13] = mk(32'h20,       1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h12345678);
      tbl[14] = mk(32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h12345678);

      reset = 1'b1;
      drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clock);
      #1;
      check("reset_saida1_valida", {31'd0, saida1_valida}, 32'd0);
      check("reset_saida2_valida", {31'd0, saida2_valida}, 32'd0);
      check("reset_saida1", saida1, 32'h0);
      check("reset_saida2", saida2, 32'h0);
      check("reset_entrada_pronta", {31'd0, entrada_pronta}, 32'd1);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 15; i++) begin
         @(negedge clock);
         drive(tbl[i].din, tbl[i].val, tbl[i].sel, tbl[i].p1, tbl[i].p2);
         #1;
         check($sformatf("vec%0d_entrada_pronta", i), {31'd0, entrada_pronta}, {31'd0, tbl[i].rdy});
         @(posedge clock);
         #1;
         check($sformatf("vec%0d_saida1_valida", i), {31'd0, saida1_valida}, {31'd0, tbl[i].v1});
         check($sformatf("vec%0d_saida2_valida", i), {31'd0, saida2_valida}, {31'd0, tbl[i].v2});
         check($sformatf("vec%0d_saida1", i), saida1, tbl[i].s1);
         check($sformatf("vec%0d_saida2", i), saida2, tbl[i].s2);
      end
`ifdef DEMUX_CONTADOR_EN
      // Channel 1 drained on vectors 1,6,8,9,10,11,13,14; channel 2 on vector 6
      check("vec_contador1", contador1, 32'd8);
      check("vec_contador2", contador2, 32'd1);
`endif

      // Fill both channels with consumers stalled, then reset asynchronously mid-cycle
      @(negedge clock);
      drive(32'h11111111, 1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clock);
      drive(32'h22222222, 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clock);
      #1;
      check("prereset_both_full", {30'd0, saida1_valida, saida2_valida}, 32'd3);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_saida1_valida", {31'd0, saida1_valida}, 32'd0);
      check("async_reset_saida2_valida", {31'd0, saida2_valida}, 32'd0);
      check("async_reset_saida1", saida1, 32'h0);
      check("async_reset_saida2", saida2, 32'h0);
`ifdef DEMUX_CONTADOR_EN
      check("async_reset_contador1", contador1, 32'd0);
`endif
      @(negedge clock);
      drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      #1;
      check("post_reset_entrada_pronta", {31'd0, entrada_pronta}, 32'd1);
      @(posedge clock);
      #1;
      check("post_reset_idle_valida", {30'd0, saida1_valida, saida2_valida}, 32'd0);

      // Randomized traffic against the queue model
      model_reset();
      for (int n = 0; n < 400; n++) begin
         rand_step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
